// File: rtl/ifu_fetch_resp_pkg.sv
// ifu_fetch_resp_pkg: shared widths, opcode constant and FSM state encoding
// for the instruction-fetch responder and its aligner.
package ifu_fetch_resp_pkg;

  localparam int XLEN     = 64;
  localparam int INST_LEN = 32;

  // Low two opcode bits of every 32-bit instruction.
  localparam logic [1:0] OPC_32B = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_WAIT    = 3'd2,
    S_REQ_HI  = 3'd3,
    S_WAIT_HI = 3'd4,
    S_OUT     = 3'd5
  } state_e;

endpackage

// File: rtl/ifu_fetch_resp_if.sv
// ifu_fetch_resp_if: AXI-like AR/R read bus between fetch unit and imem.
// master = fetch unit (drives arvalid/araddr/rready), slave = memory.
interface ifu_fetch_resp_if #(
  parameter int ADDR_W = 64,
  parameter int BUS_W  = 64
);

  logic              arvalid;
  logic [ADDR_W-1:0] araddr;
  logic              arready;
  logic              rvalid;
  logic [BUS_W-1:0]  rdata;
  logic              rready;

  modport master (
    output arvalid, araddr, rready,
    input  arready, rvalid, rdata
  );

  modport slave (
    input  arvalid, araddr, rready,
    output arready, rvalid, rdata
  );

endinterface

// File: rtl/ifu_inst_align.sv
// ifu_inst_align: picks the 16/32-bit instruction at pc[2:1] out of a
// 64-bit line. Ports: rdata_i, off_i, lo_i, hi_i -> inst_o, cmp_o, needs_hi_o.
module ifu_inst_align
  import ifu_fetch_resp_pkg::*;
(
  input  logic [63:0]         rdata_i,
  input  logic [1:0]          off_i,
  input  logic [15:0]         lo_i,
  input  logic                hi_i,
  output logic [INST_LEN-1:0] inst_o,
  output logic                cmp_o,
  output logic                needs_hi_o
);

  logic [63:0] h;

  always_comb begin
    h          = rdata_i >> {off_i, 4'b0};
    inst_o     = h[31:0];
    cmp_o      = 1'b0;
    needs_hi_o = 1'b0;
    if (hi_i) begin
      // Upper half of a straddling instruction sits at the next line's start.
      inst_o = {rdata_i[15:0], lo_i};
    end else if (h[1:0] != OPC_32B) begin
      inst_o = {16'b0, h[15:0]};
      cmp_o  = 1'b1;
    end else if (off_i == 2'b11) begin
      // inst_o[15:0] carries the low half to be saved.
      needs_hi_o = 1'b1;
    end
  end

endmodule

// File: rtl/ifu_fetch_resp.sv
// ifu_fetch_resp: accepts fetch PCs, reads 64-bit lines over mem (AR/R),
// returns inst_o/inst_pc_o/is_compressed_o with stall, flush and straddle
// handling. Optional IFU_LINE_BUF_EN adds a 1-entry line buffer.
module ifu_fetch_resp
  import ifu_fetch_resp_pkg::*;
#(
  parameter int ADDR_W = XLEN,
  parameter int BUS_W  = 64,
  parameter int INST_W = INST_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  input  logic [ADDR_W-1:0] req_pc_i,
  output logic              req_ready_o,
  input  logic              stall_i,
  input  logic              flush_i,
  ifu_fetch_resp_if.master  mem,
  output logic              inst_valid_o,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic              is_compressed_o
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              cmp_q, cmp_d;
  logic [15:0]       lo_q, lo_d;
  logic              discard_q, discard_d;

  logic [ADDR_W-1:0] base, hi_addr;
  logic [BUS_W-1:0]  rdata;
  logic              accept, drop;
  logic [INST_W-1:0] al_inst;
  logic              al_cmp, al_hi;

  assign base    = {pc_q[ADDR_W-1:3], 3'b0};
  assign hi_addr = base + ADDR_W'(8);
  assign rdata   = mem.rdata;
  assign drop    = discard_q | flush_i;

  assign req_ready_o = ~rst & ~flush_i &
    ((state_q == S_IDLE) |
     ((state_q == S_OUT) & ~stall_i));
  assign accept = req_valid_i & req_ready_o;

  assign mem.arvalid = ~rst &
    ((state_q == S_REQ) | (state_q == S_REQ_HI));
  assign mem.araddr =
    (state_q == S_REQ)    ? base :
    (state_q == S_REQ_HI) ? hi_addr : '0;
  assign mem.rready = ~rst &
    ((state_q == S_WAIT) | (state_q == S_WAIT_HI));

  assign inst_valid_o    = ~rst & ~flush_i & (state_q == S_OUT);
  assign inst_o          = inst_q;
  assign inst_pc_o       = pc_q;
  assign is_compressed_o = cmp_q;

  ifu_inst_align u_align (
    .rdata_i    (rdata),
    .off_i      (pc_q[2:1]),
    .lo_i       (lo_q),
    .hi_i       (state_q == S_WAIT_HI),
    .inst_o     (al_inst),
    .cmp_o      (al_cmp),
    .needs_hi_o (al_hi)
  );

`ifdef IFU_LINE_BUF_EN
  logic              lb_vld_q, lb_vld_d;
  logic [ADDR_W-4:0] lb_tag_q, lb_tag_d;
  logic [BUS_W-1:0]  lb_dat_q, lb_dat_d;
  logic [INST_W-1:0] lb_inst;
  logic              lb_cmp, lb_hi, lb_hit;

  assign lb_hit = lb_vld_q &
    (lb_tag_q == req_pc_i[ADDR_W-1:3]);

  ifu_inst_align u_lb_align (
    .rdata_i    (lb_dat_q),
    .off_i      (req_pc_i[2:1]),
    .lo_i       (16'b0),
    .hi_i       (1'b0),
    .inst_o     (lb_inst),
    .cmp_o      (lb_cmp),
    .needs_hi_o (lb_hi)
  );

  always_comb begin
    lb_vld_d = lb_vld_q;
    lb_tag_d = lb_tag_q;
    lb_dat_d = lb_dat_q;
    if (mem.rvalid & ~drop) begin
      if (state_q == S_WAIT) begin
        lb_vld_d = 1'b1;
        lb_tag_d = pc_q[ADDR_W-1:3];
        lb_dat_d = rdata;
      end else if (state_q == S_WAIT_HI) begin
        lb_vld_d = 1'b1;
        lb_tag_d = hi_addr[ADDR_W-1:3];
        lb_dat_d = rdata;
      end
    end
    if (flush_i) lb_vld_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lb_vld_q <= 1'b0;
      lb_tag_q <= '0;
      lb_dat_q <= '0;
    end else begin
      lb_vld_q <= lb_vld_d;
      lb_tag_q <= lb_tag_d;
      lb_dat_q <= lb_dat_d;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    cmp_d     = cmp_q;
    lo_d      = lo_q;
    discard_d = discard_q;
    unique case (state_q)
      S_IDLE: ;
      S_REQ: begin
        if (flush_i) discard_d = 1'b1;
        if (mem.arready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (flush_i) discard_d = 1'b1;
        if (mem.rvalid) begin
          if (drop) begin
            state_d = S_IDLE;
          end else if (al_hi) begin
            lo_d    = al_inst[15:0];
            state_d = S_REQ_HI;
          end else begin
            inst_d  = al_inst;
            cmp_d   = al_cmp;
            state_d = S_OUT;
          end
        end
      end
      S_REQ_HI: begin
        if (flush_i) discard_d = 1'b1;
        if (mem.arready) state_d = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (flush_i) discard_d = 1'b1;
        if (mem.rvalid) begin
          if (drop) begin
            state_d = S_IDLE;
          end else begin
            inst_d  = al_inst;
            cmp_d   = 1'b0;
            state_d = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (flush_i | ~stall_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Requests are only accepted in IDLE or an unstalled OUT.
    if (accept) begin
      pc_d    = req_pc_i;
      state_d = S_REQ;
`ifdef IFU_LINE_BUF_EN
      if (lb_hit) begin
        if (lb_hi) begin
          lo_d    = lb_inst[15:0];
          state_d = S_REQ_HI;
        end else begin
          inst_d  = lb_inst;
          cmp_d   = lb_cmp;
          state_d = S_OUT;
        end
      end
`endif
    end
    if (state_d == S_IDLE) discard_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      inst_q    <= '0;
      cmp_q     <= 1'b0;
      lo_q      <= '0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      cmp_q     <= cmp_d;
      lo_q      <= lo_d;
      discard_q <= discard_d;
    end
  end

endmodule

// File: tb/tb_ifu_fetch_resp.sv
// tb_ifu_fetch_resp: directed tests for ifu_fetch_resp
// (aligned, compressed, straddle, wrap, stall, flush, reset, line buffer).
module tb_ifu_fetch_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [63:0] req_pc = '0;
  logic        req_ready;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        cmp;

  int vecs = 0;
  int errs = 0;

  ifu_fetch_resp_if bus ();

  ifu_fetch_resp dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid_i     (req_valid),
    .req_pc_i        (req_pc),
    .req_ready_o     (req_ready),
    .stall_i         (stall),
    .flush_i         (flush),
    .mem             (bus),
    .inst_valid_o    (inst_valid),
    .inst_o          (inst),
    .inst_pc_o       (inst_pc),
    .is_compressed_o (cmp)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_pulse();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    bus.rdata   = '0;
    req_valid   = 1'b1;
    req_pc      = 64'h8000_0000;
    step();
    step();
    #1;
    vecs++;
    if (req_ready !== 1'b0)
      $display("FAIL reset_ready: got %b want 0", req_ready);
    vecs++;
    if ({bus.arvalid, bus.rready, inst_valid, cmp, inst, inst_pc}
        !== 100'b0)
      $display("FAIL reset_outs: av=%b rr=%b iv=%b c=%b i=%h pc=%h want all 0",
        bus.arvalid, bus.rready, inst_valid, cmp, inst, inst_pc);
    if ({bus.arvalid, bus.rready, inst_valid, cmp, inst, inst_pc} !== 100'b0)
      errs++;
    if (req_ready !== 1'b0) errs++;
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    vecs++;
    if (req_ready !== 1'b1) begin
      errs++;
      $display("FAIL reset_release_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic test_aligned();
    flush_pulse();
    req_pc = 64'h8000_0000;
    req_valid = 1'b1;
    #1;
    vecs++;
    if (req_ready !== 1'b1) begin
      errs++;
      $display("FAIL al_ready: got %b want 1", req_ready);
    end
    step();
    req_valid = 1'b0;
    bus.arready = 1'b1;
    #1;
    vecs++;
    if ({bus.arvalid, bus.araddr} !== {1'b1, 64'h8000_0000}) begin
      errs++;
      $display("FAIL al_ar: got %b %h want 1 80000000",
        bus.arvalid, bus.araddr);
    end
    step();
    bus.arready = 1'b0;
    bus.rvalid = 1'b1;
    bus.rdata = 64'h0000_0000_0000_0413;
    #1;
    vecs++;
    if ({bus.arvalid, bus.rready, inst_valid} !== 3'b010) begin
      errs++;
      $display("FAIL al_wait: got av/rr/iv=%b want 010",
        {bus.arvalid, bus.rready, inst_valid});
    end
    step();
    bus.rvalid = 1'b0;
    #1;
    vecs++;
    if ({inst_valid, inst, cmp, inst_pc} !==
        {1'b1, 32'h0000_0413, 1'b0, 64'h8000_0000}) begin
      errs++;
      $display("FAIL al_out: got v=%b i=%h c=%b pc=%h want 1 00000413 0 80000000",
        inst_valid, inst, cmp, inst_pc);
    end
    step();
    #1;
    vecs++;
    if ({inst_valid, bus.arvalid, req_ready} !== 3'b001) begin
      errs++;
      $display("FAIL al_idle: got iv/av/rdy=%b want 001",
        {inst_valid, bus.arvalid, req_ready});
    end
  endtask

  task automatic test_compressed();
    flush_pulse();
    req_pc = 64'h8000_0006;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      vecs++;
      if ({bus.arvalid, bus.araddr} !== {1'b1, 64'h8000_0000}) begin
        errs++;
        $display("FAIL cmp_ar_hold%0d: got %b %h want 1 80000000",
          i, bus.arvalid, bus.araddr);
      end
      step();
    end
    bus.arready = 1'b1;
    step();
    bus.arready = 1'b0;
    bus.rvalid = 1'b1;
    bus.rdata = 64'h4501_2222_3333_1111;
    step();
    bus.rvalid = 1'b0;
    #1;
    vecs++;
    if ({inst_valid, inst, cmp, inst_pc, bus.arvalid} !==
        {1'b1, 32'h0000_4501, 1'b1, 64'h8000_0006, 1'b0}) begin
      errs++;
      $display("FAIL cmp_out: got v=%b i=%h c=%b pc=%h av=%b want 1 00004501 1 80000006 0",
        inst_valid, inst, cmp, inst_pc, bus.arvalid);
    end
    step();
  endtask

  task automatic test_straddle(input logic [63:0] pc,
                               input logic [63:0] a0,
                               input logic [63:0] d0,
                               input logic [63:0] a1,
                               input logic [63:0] d1,
                               input logic [31:0] exp);
    flush_pulse();
    req_pc = pc;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    bus.arready = 1'b1;
    #1;
    vecs++;
    if ({bus.arvalid, bus.araddr} !== {1'b1, a0}) begin
      errs++;
      $display("FAIL st_ar0: got %b %h want 1 %h",
        bus.arvalid, bus.araddr, a0);
    end
    step();
    bus.arready = 1'b0;
    bus.rvalid = 1'b1;
    bus.rdata = d0;
    step();
    bus.rvalid = 1'b0;
    bus.arready = 1'b1;
    #1;
    vecs++;
    if ({bus.arvalid, bus.araddr, inst_valid} !== {1'b1, a1, 1'b0}) begin
      errs++;
      $display("FAIL st_ar1: got %b %h iv=%b want 1 %h 0",
        bus.arvalid, bus.araddr, inst_valid, a1);
    end
    step();
    bus.arready = 1'b0;
    bus.rvalid = 1'b1;
    bus.rdata = d1;
    #1;
    vecs++;
    if ({bus.rready, inst_valid} !== 2'b10) begin
      errs++;
      $display("FAIL st_wait_hi: got rr/iv=%b want 10",
        {bus.rready, inst_valid});
    end
    step();
    bus.rvalid = 1'b0;
    #1;
    vecs++;
    if ({inst_valid, inst, cmp, inst_pc} !== {1'b1, exp, 1'b0, pc}) begin
      errs++;
      $display("FAIL st_out: got v=%b i=%h c=%b pc=%h want 1 %h 0 %h",
        inst_valid, inst, cmp, inst_pc, exp, pc);
    end
    step();
  endtask

  task automatic test_stall();
    flush_pulse();
    req_pc = 64'h8000_0040;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    bus.arready = 1'b1;
    step();
    bus.arready = 1'b0;
    bus.rvalid = 1'b1;
    bus.rdata = 64'h0000_0000_0010_0093;
    step();
    bus.rvalid = 1'b0;
    stall = 1'b1;
    req_valid = 1'b1;
    req_pc = 64'h8000_0020;
    for (int i = 0; i < 5; i++) begin
      #1;
      vecs++;
      if ({inst_valid, inst, inst_pc, cmp, req_ready} !==
          {1'b1, 32'h0010_0093, 64'h8000_0040, 1'b0, 1'b0}) begin
        errs++;
        $display("FAIL stall_hold%0d: v=%b i=%h pc=%h c=%b rdy=%b want 1 00100093 80000040 0 0",
          i, inst_valid, inst, inst_pc, cmp, req_ready);
      end
      step();
    end
    stall = 1'b0;
    #1;
    vecs++;
    if ({req_ready, inst_valid} !== 2'b11) begin
      errs++;
      $display("FAIL stall_release: got rdy/iv=%b want 11",
        {req_ready, inst_valid});
    end
    step();
    req_valid = 1'b0;
    bus.arready = 1'b1;
    #1;
    vecs++;
    if ({bus.arvalid, bus.araddr, inst_valid} !==
        {1'b1, 64'h8000_0020, 1'b0}) begin
      errs++;
      $display("FAIL stall_next_ar: got %b %h iv=%b want 1 80000020 0",
        bus.arvalid, bus.araddr, inst_valid);
    end
    step();
    bus.arready = 1'b0;
    bus.rvalid = 1'b1;
    bus.rdata = 64'h0000_0000_0000_0013;
    step();
    bus.rvalid = 1'b0;
    #1;
    vecs++;
    if ({inst_valid, inst, inst_pc} !==
        {1'b1, 32'h0000_0013, 64'h8000_0020}) begin
      errs++;
      $display("FAIL stall_next_out: got v=%b i=%h pc=%h want 1 00000013 80000020",
        inst_valid, inst, inst_pc);
    end
    step();
  endtask

  task automatic test_flush_wait();
    flush_pulse();
    req_pc = 64'h8000_0100;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    bus.arready = 1'b1;
    step();
    bus.arready = 1'b0;
    flush = 1'b1;
    #1;
    vecs++;
    if ({bus.rready, inst_valid, req_ready} !== 3'b100) begin
      errs++;
      $display("FAIL fw_flush: got rr/iv/rdy=%b want 100",
        {bus.rready, inst_valid, req_ready});
    end
    step();
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      vecs++;
      if ({bus.rready, inst_valid} !== 2'b10) begin
        errs++;
        $display("FAIL fw_wait%0d: got rr/iv=%b want 10",
          i, {bus.rready, inst_valid});
      end
      step();
    end
    bus.rvalid = 1'b1;
    bus.rdata = 64'h0000_0000_0000_0413;
    step();
    bus.rvalid = 1'b0;
    #1;
    vecs++;
    if ({inst_valid, bus.arvalid, bus.rready, req_ready} !== 4'b0001) begin
      errs++;
      $display("FAIL fw_drop: got iv/av/rr/rdy=%b want 0001",
        {inst_valid, bus.arvalid, bus.rready, req_ready});
    end
    step();
    #1;
    vecs++;
    if (inst_valid !== 1'b0) begin
      errs++;
      $display("FAIL fw_after: got iv=%b want 0", inst_valid);
    end
  endtask

  task automatic test_flush_out();
    flush_pulse();
    req_pc = 64'h8000_0080;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    bus.arready = 1'b1;
    step();
    bus.arready = 1'b0;
    bus.rvalid = 1'b1;
    bus.rdata = 64'h0000_0000_0000_0013;
    step();
    bus.rvalid = 1'b0;
    flush = 1'b1;
    req_valid = 1'b1;
    req_pc = 64'h8000_0300;
    #1;
    vecs++;
    if ({inst_valid, req_ready} !== 2'b00) begin
      errs++;
      $display("FAIL fo_mask: got iv/rdy=%b want 00",
        {inst_valid, req_ready});
    end
    step();
    flush = 1'b0;
    req_valid = 1'b0;
    #1;
    vecs++;
    if ({bus.arvalid, inst_valid, req_ready} !== 3'b001) begin
      errs++;
      $display("FAIL fo_idle: got av/iv/rdy=%b want 001",
        {bus.arvalid, inst_valid, req_ready});
    end
  endtask

  task automatic test_reset_mid();
    flush_pulse();
    req_pc = 64'h8000_0400;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    bus.arready = 1'b1;
    step();
    bus.arready = 1'b0;
    rst = 1'b1;
    #1;
    vecs++;
    if ({bus.rready, req_ready} !== 2'b00) begin
      errs++;
      $display("FAIL rm_during: got rr/rdy=%b want 00",
        {bus.rready, req_ready});
    end
    step();
    rst = 1'b0;
    #1;
    vecs++;
    if ({bus.arvalid, bus.rready, inst_valid, req_ready} !== 4'b0001) begin
      errs++;
      $display("FAIL rm_idle: got av/rr/iv/rdy=%b want 0001",
        {bus.arvalid, bus.rready, inst_valid, req_ready});
    end
  endtask

  task automatic test_line_buf();
    flush_pulse();
    req_pc = 64'h8000_0200;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    bus.arready = 1'b1;
    step();
    bus.arready = 1'b0;
    bus.rvalid = 1'b1;
    bus.rdata = 64'h0000_0013_0000_0413;
    step();
    bus.rvalid = 1'b0;
    #1;
    vecs++;
    if ({inst_valid, inst} !== {1'b1, 32'h0000_0413}) begin
      errs++;
      $display("FAIL lb_first: got v=%b i=%h want 1 00000413",
        inst_valid, inst);
    end
    step();
    req_pc = 64'h8000_0204;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    #1;
`ifdef IFU_LINE_BUF_EN
    vecs++;
    if ({inst_valid, bus.arvalid, inst, inst_pc} !==
        {1'b1, 1'b0, 32'h0000_0013, 64'h8000_0204}) begin
      errs++;
      $display("FAIL lb_hit: got v=%b av=%b i=%h pc=%h want 1 0 00000013 80000204",
        inst_valid, bus.arvalid, inst, inst_pc);
    end
`else
    vecs++;
    if ({bus.arvalid, bus.araddr, inst_valid} !==
        {1'b1, 64'h8000_0200, 1'b0}) begin
      errs++;
      $display("FAIL lb_nobuf_ar: got %b %h iv=%b want 1 80000200 0",
        bus.arvalid, bus.araddr, inst_valid);
    end
    bus.arready = 1'b1;
    step();
    bus.arready = 1'b0;
    bus.rvalid = 1'b1;
    bus.rdata = 64'h0000_0013_0000_0413;
    step();
    bus.rvalid = 1'b0;
    #1;
    vecs++;
    if ({inst_valid, inst, inst_pc} !==
        {1'b1, 32'h0000_0013, 64'h8000_0204}) begin
      errs++;
      $display("FAIL lb_nobuf_out: got v=%b i=%h pc=%h want 1 00000013 80000204",
        inst_valid, inst, inst_pc);
    end
`endif
    step();
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_compressed();
    test_straddle(64'h8000_000E,
                  64'h8000_0008, 64'h0513_0000_0000_0000,
                  64'h8000_0010, 64'hDEAD_BEEF_CAFE_0000,
                  32'h0000_0513);
    test_straddle(64'hFFFF_FFFF_FFFF_FFFE,
                  64'hFFFF_FFFF_FFFF_FFF8, 64'h0003_0000_0000_0000,
                  64'h0000_0000_0000_0000, 64'h0000_0000_0000_1234,
                  32'h1234_0003);
    test_stall();
    test_flush_wait();
    test_flush_out();
    test_reset_mid();
    test_line_buf();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
